// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for an RV32I in-order core: operand capture with writeback
// bypass, immediate generation, load-use bubble insertion, and flush/backpressure control.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_op_a,
    output logic [31:0] ex_op_b,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_funct3,
    output logic        ex_funct7b5,
    output logic        ex_memread
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    function automatic logic [31:0] imm_gen(input logic [31:0] i);
        logic [31:0] imm;
        imm = '0;
        case (i[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR:
                imm = {{20{i[31]}}, i[31:20]};
            OPC_STORE:
                imm = {{20{i[31]}}, i[31:25], i[11:7]};
            OPC_BRANCH:
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {i[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

    // x0 reads as zero; a same-cycle writeback to the source wins over the stale RF data.
    function automatic logic [31:0] bypass(input logic [4:0] addr, input logic [31:0] rf_data,
                                           input logic we, input logic [4:0] wa,
                                           input logic [31:0] wd);
        logic [31:0] val;
        if (addr == 5'd0)
            val = '0;
        else if (we && (wa == addr))
            val = wd;
        else
            val = rf_data;
        return val;
    endfunction

    logic [6:0]  opcode;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        hazard;
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign opcode   = id_instr[6:0];
    assign rs1_addr = id_instr[19:15];
    assign rs2_addr = id_instr[24:20];

    assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign hazard = ex_valid && ex_memread && (ex_rd != 5'd0) && id_valid &&
                    ((uses_rs1 && (rs1_addr == ex_rd)) || (uses_rs2 && (rs2_addr == ex_rd)));

    assign id_stall = !flush && (hazard || !ex_ready);

    assign op_a = bypass(rs1_addr, rs1_data, wb_regwrite, wb_rd, wb_data);
    assign op_b = bypass(rs2_addr, rs2_data, wb_regwrite, wb_rd, wb_data);

    // ID -> EX register; a bubble or flush only clears valid, the payload holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_op_a     <= '0;
            ex_op_b     <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_memread  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!ex_ready) begin
            ex_valid <= ex_valid;
        end else if (hazard) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_op_a     <= op_a;
            ex_op_b     <= op_b;
            ex_imm      <= imm_gen(id_instr);
            ex_rd       <= id_instr[11:7];
            ex_rs1      <= rs1_addr;
            ex_rs2      <= rs2_addr;
            ex_opcode   <= opcode;
            ex_funct3   <= id_instr[14:12];
            ex_funct7b5 <= id_instr[30];
            ex_memread  <= (opcode == OPC_LOAD);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode/capture, bypass, immediates, load-use,
// backpressure, flush priority and asynchronous reset.
module tb_id_ex_stage;

    logic        clk;
    logic        reset_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_memread;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] I_ADDI = 32'h0070_0293; // addi x5,x0,7
    localparam logic [31:0] I_ADD  = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_SW   = 32'hFE20_AE23; // sw   x2,-4(x1)
    localparam logic [31:0] I_BEQ  = 32'hFE20_8CE3; // beq  x1,x2,-8
    localparam logic [31:0] I_JAL  = 32'h0010_00EF; // jal  x1,+2048
    localparam logic [31:0] I_LUI  = 32'h1234_53B7; // lui  x7,0x12345
    localparam logic [31:0] I_LW   = 32'h0000_A203; // lw   x4,0(x1)
    localparam logic [31:0] I_ADD6 = 32'h0042_0333; // add  x6,x4,x4

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
        .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_memread(ex_memread)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        id_valid = v;
        id_instr = ins;
        id_pc    = pc;
    endtask

    initial begin
        reset_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc = '0;
        rs1_data = '0; rs2_data = '0; wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
        ex_ready = 1'b1; flush = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_memread", 32'(ex_memread), 32'd0);
        chk("rst_stall", 32'(id_stall), 32'd0);
        ex_ready = 1'b0;
        #1;
        chk("rst_stall_notready", 32'(id_stall), 32'd1);
        ex_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        // ADDI x5,x0,7; a writeback to x0 must not leak into operand a
        drive(1'b1, I_ADDI, 32'h100);
        rs1_data = 32'h55; rs2_data = 32'h66;
        wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'h99;
        #1;
        chk("addi_rs1_addr", 32'(rs1_addr), 32'd0);
        chk("addi_rs2_addr", 32'(rs2_addr), 32'd7);
        tick();
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_rd", 32'(ex_rd), 32'd5);
        chk("addi_imm", ex_imm, 32'd7);
        chk("addi_op_a", ex_op_a, 32'd0);
        chk("addi_pc", ex_pc, 32'h100);
        chk("addi_opcode", 32'(ex_opcode), 32'h13);

        // ADD x3,x1,x2 with WB bypass on x1
        drive(1'b1, I_ADD, 32'h104);
        rs1_data = 32'h11; rs2_data = 32'h22;
        wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 32'hAA;
        #1;
        chk("add_rs1_addr", 32'(rs1_addr), 32'd1);
        chk("add_rs2_addr", 32'(rs2_addr), 32'd2);
        tick();
        chk("add_op_a_bypass", ex_op_a, 32'hAA);
        chk("add_op_b", ex_op_b, 32'h22);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_memread", 32'(ex_memread), 32'd0);

        // Immediate formats
        wb_regwrite = 1'b0;
        drive(1'b1, I_SW, 32'h108);
        rs1_data = 32'h1000; rs2_data = 32'h33;
        tick();
        chk("sw_imm", ex_imm, 32'hFFFF_FFFC);
        chk("sw_op_b", ex_op_b, 32'h33);
        chk("sw_funct3", 32'(ex_funct3), 32'd2);
        drive(1'b1, I_BEQ, 32'h10C);
        tick();
        chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
        drive(1'b1, I_JAL, 32'h110);
        tick();
        chk("jal_imm", ex_imm, 32'h0000_0800);
        drive(1'b1, I_LUI, 32'h114);
        tick();
        chk("lui_imm", ex_imm, 32'h1234_5000);
        chk("lui_rd", 32'(ex_rd), 32'd7);

        // Load-use: one bubble, then the consumer is captured
        drive(1'b1, I_LW, 32'h200);
        rs1_data = 32'h1000;
        tick();
        chk("lw_memread", 32'(ex_memread), 32'd1);
        chk("lw_rd", 32'(ex_rd), 32'd4);
        drive(1'b1, I_ADD6, 32'h204);
        rs1_data = 32'h44; rs2_data = 32'h44;
        #1;
        chk("lu_stall", 32'(id_stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_pc_hold", ex_pc, 32'h200);
        chk("lu_stall_released", 32'(id_stall), 32'd0);
        tick();
        chk("lu_capture_valid", 32'(ex_valid), 32'd1);
        chk("lu_capture_pc", ex_pc, 32'h204);
        chk("lu_capture_rd", 32'(ex_rd), 32'd6);
        chk("lu_capture_op_a", ex_op_a, 32'h44);

        // Backpressure for 3 cycles; a WB to x4 must not refresh the held operand
        ex_ready = 1'b0;
        drive(1'b1, I_ADDI, 32'h300);
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_data = 32'h77;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_stall_%0d", i), 32'(id_stall), 32'd1);
            tick();
            chk($sformatf("bp_pc_hold_%0d", i), ex_pc, 32'h204);
            chk($sformatf("bp_op_a_hold_%0d", i), ex_op_a, 32'h44);
            chk($sformatf("bp_valid_hold_%0d", i), 32'(ex_valid), 32'd1);
        end
        ex_ready = 1'b1; wb_regwrite = 1'b0;
        tick();
        chk("bp_release_pc", ex_pc, 32'h300);
        chk("bp_release_rd", 32'(ex_rd), 32'd5);

        // Flush wins over a simultaneous load-use hazard
        drive(1'b1, I_LW, 32'h400);
        tick();
        chk("fl_lw_valid", 32'(ex_valid), 32'd1);
        drive(1'b1, I_ADD6, 32'h404);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(id_stall), 32'd0);
        tick();
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_pc_hold", ex_pc, 32'h400);
        flush = 1'b0;

        // id_valid=0 behind a load: no hazard, invalid slot loaded
        drive(1'b1, I_LW, 32'h500);
        tick();
        chk("iv_lw_valid", 32'(ex_valid), 32'd1);
        drive(1'b0, I_ADD6, 32'h504);
        #1;
        chk("iv_stall", 32'(id_stall), 32'd0);
        tick();
        chk("iv_valid", 32'(ex_valid), 32'd0);
        chk("iv_pc", ex_pc, 32'h504);

        // Asynchronous reset mid-cycle
        drive(1'b1, I_ADDI, 32'h600);
        tick();
        chk("ar_pre_valid", 32'(ex_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(ex_valid), 32'd0);
        chk("ar_pc", ex_pc, 32'd0);
        chk("ar_imm", ex_imm, 32'd0);
        chk("ar_rd", 32'(ex_rd), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 32'd0, 32'd0);
        tick();
        chk("post_rst_valid", 32'(ex_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
